// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 inverse cipher. One round is consumed per subkey_valid cycle, with round keys read from Nr down to 0.
// Optional feature macro: AES_DEC_DONE_PULSE_EN adds a one-cycle 'done' output.
module aes_decrypt_iter #(
    parameter int KEY_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [127:0]          ciphertext,
    input  logic [127:0]          subkey,
    input  logic                  subkey_valid,
    output logic [KEY_ADDR_W-1:0] subkey_addr,
    output logic [127:0]          plaintext,
    output logic                  ready
`ifdef AES_DEC_DONE_PULSE_EN
    ,
    output logic                  done
`endif
);

    typedef enum logic [1:0] {IDLE, INIT, ROUND} state_t;

    state_t         state, state_nxt;
    logic           accept, ld_init, ld_round, ld_final;
    logic [127:0]   ct_q;
    logic [127:0]   sr, sb, ark, mc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ t;
            t = xtime(t);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Tower inversion: a^17 is the norm into the GF(16) subfield, inverted there as n^14,
    // and a^-1 = a^16 * (a^17)^-1. The inverse affine map is applied to the input byte first.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a, a16, n, n2, n4, n8;
        a   = inv_affine(x);
        a16 = gf_sq(gf_sq(gf_sq(gf_sq(a))));
        n   = gf_mul(a16, a);
        n2  = gf_sq(n);
        n4  = gf_sq(n2);
        n8  = gf_sq(n4);
        return gf_mul(a16, gf_mul(gf_mul(n2, n4), n8));
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    function automatic logic [KEY_ADDR_W-1:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b01:   return KEY_ADDR_W'(10);
            2'b10:   return KEY_ADDR_W'(12);
            default: return KEY_ADDR_W'(14);
        endcase
    endfunction

    // Byte k of the state is bits [127-8k -: 8]; row r / column c is byte 4c+r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4*c + r;
            localparam int SRC = 4*((c - r + 4) % 4) + r;
            assign sr[127-8*DST -: 8] = plaintext[127-8*SRC -: 8];
            assign sb[127-8*DST -: 8] = inv_sbox(sr[127-8*DST -: 8]);
        end
        assign mc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign ark = sb ^ subkey;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && key_len != 2'b00) state_nxt = INIT;
            INIT:    if (subkey_valid) state_nxt = ROUND;
            ROUND:   if (subkey_valid && subkey_addr == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        ld_init  = 1'b0;
        ld_round = 1'b0;
        ld_final = 1'b0;
        case (state)
            IDLE:    accept   = start && key_len != 2'b00;
            INIT:    ld_init  = subkey_valid;
            ROUND: begin
                ld_round = subkey_valid && subkey_addr != '0;
                ld_final = subkey_valid && subkey_addr == '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ct_q        <= '0;
            plaintext   <= '0;
            subkey_addr <= '0;
            ready       <= 1'b1;
        end else begin
            if (accept) begin
                ct_q        <= ciphertext;
                subkey_addr <= nr_of(key_len);
                ready       <= 1'b0;
            end
            if (ld_init) begin
                plaintext   <= ct_q ^ subkey;
                subkey_addr <= subkey_addr - KEY_ADDR_W'(1);
            end
            if (ld_round) begin
                plaintext   <= mc;
                subkey_addr <= subkey_addr - KEY_ADDR_W'(1);
            end
            if (ld_final) begin
                plaintext   <= ark;
                ready       <= 1'b1;
            end
        end
    end

`ifdef AES_DEC_DONE_PULSE_EN
    always_ff @(posedge clk) begin
        if (reset) done <= 1'b0;
        else       done <= ld_final;
    end
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using the FIPS-197 App.C vectors; the key RAM is modelled from an independent key expansion.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         reset, start, subkey_valid;
    logic [1:0]   key_len;
    logic [127:0] ciphertext, subkey, plaintext;
    logic [3:0]   subkey_addr;
    logic         ready;
`ifdef AES_DEC_DONE_PULSE_EN
    logic         done;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] rk [16];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK   = 128'hdeadbeefcafef00d0123456789abcdef;

    always #5 clk = ~clk;

    assign subkey = rk[subkey_addr];

    aes_decrypt_iter #(.KEY_ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .key_len(key_len),
        .ciphertext(ciphertext), .subkey(subkey), .subkey_valid(subkey_valid),
        .subkey_addr(subkey_addr), .plaintext(plaintext), .ready(ready)
`ifdef AES_DEC_DONE_PULSE_EN
        , .done(done)
`endif
    );

    function automatic logic [7:0] g_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse search, then the forward affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && g_mul(x, 8'(y)) == 8'h01) s = 8'(y);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    task automatic build_keys(input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: subkey_valid held high; mode 1: valid low on every other cycle after the start edge.
    // inj_edge > 0 pulses a conflicting start request just before that edge.
    task automatic run(input string tag, input logic [127:0] ct, input logic [1:0] kl,
                       input int exp_edge, input int mode, input int inj_edge);
        int nr, got, exp_a, dcnt;
        logic pv;
        logic [3:0] pa;
        nr = 8 + 2*int'(kl);
        build_keys(nr - 6);
        ciphertext = ct; key_len = kl; start = 1'b1; subkey_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ciphertext = ~ct; key_len = 2'b00;
        chk({tag, " busy"}, 128'(ready), 128'(0));
        chk({tag, " addr_nr"}, 128'(subkey_addr), 128'(nr));
        got = 0; dcnt = 0;
        for (int e = 2; e <= 60 && got == 0; e++) begin
            if (mode == 1) subkey_valid = (e % 2 == 1);
            pv = subkey_valid; pa = subkey_addr;
            if (e == inj_edge) begin start = 1'b1; ciphertext = JUNK; key_len = 2'b11; end
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 0) begin
                exp_a = (nr - (e - 1) > 0) ? nr - (e - 1) : 0;
                chk({tag, " addr_seq"}, 128'(subkey_addr), 128'(exp_a));
            end else if (!pv) begin
                chk({tag, " addr_hold"}, 128'(subkey_addr), 128'(pa));
            end
`ifdef AES_DEC_DONE_PULSE_EN
            if (done) dcnt++;
`endif
            if (ready) got = e;
        end
        chk({tag, " ready_edge"}, 128'(got), 128'(exp_edge));
        chk({tag, " pt"}, plaintext, PT);
`ifdef AES_DEC_DONE_PULSE_EN
        chk({tag, " done_with_ready"}, 128'(done), 128'(1));
        @(posedge clk); #1;
        if (done) dcnt++;
        chk({tag, " done_once"}, 128'(dcnt), 128'(1));
`endif
        subkey_valid = 1'b1;
    endtask

    initial begin
        logic [127:0] pp;
        logic [3:0]   pa;
        reset = 1'b1; start = 1'b0; subkey_valid = 1'b1; key_len = 2'b00; ciphertext = '0;
        build_keys(4);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst ready", 128'(ready), 128'(1));
        chk("rst pt", plaintext, 128'(0));
        chk("rst addr", 128'(subkey_addr), 128'(0));
`ifdef AES_DEC_DONE_PULSE_EN
        chk("rst done", 128'(done), 128'(0));
`endif

        run("T1 aes128", CT128, 2'b01, 12, 0, 0);
        run("T2 aes192", CT192, 2'b10, 14, 0, 0);
        run("T2 aes256", CT256, 2'b11, 16, 0, 0);
        run("T3 stall",  CT128, 2'b01, 23, 1, 0);

        // Invalid key length: nothing may change.
        pp = plaintext; pa = subkey_addr;
        ciphertext = JUNK; key_len = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("T4 kl00 ready", 128'(ready), 128'(1));
        chk("T4 kl00 addr", 128'(subkey_addr), 128'(pa));
        chk("T4 kl00 pt", plaintext, pp);
`ifdef AES_DEC_DONE_PULSE_EN
        chk("T4 kl00 done", 128'(done), 128'(0));
`endif
        run("T4 busy_start", CT128, 2'b01, 12, 0, 5);

        // Reset partway through a T1 run.
        build_keys(4);
        ciphertext = CT128; key_len = 2'b01; start = 1'b1; subkey_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("T5 ready", 128'(ready), 128'(1));
        chk("T5 pt", plaintext, 128'(0));
        chk("T5 addr", 128'(subkey_addr), 128'(0));
`ifdef AES_DEC_DONE_PULSE_EN
        chk("T5 done", 128'(done), 128'(0));
`endif
        run("T5 fresh", CT128, 2'b01, 12, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
